// File: rtl/exe_stage.sv
// Execute stage: Val2 generator, ALU with NZCV flags, branch-target adder,
// status register and the EXE/MEM pipeline register.
`timescale 1ns/1ps
module exe_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  WB_EN_IN,
  input  logic                  MEM_R_EN_IN,
  input  logic                  MEM_W_EN_IN,
  input  logic                  B_IN,
  input  logic                  S_IN,
  input  logic [3:0]            EXE_CMD_IN,
  input  logic [DATA_W-1:0]     PC_IN,
  input  logic [DATA_W-1:0]     Val_Rn_IN,
  input  logic [DATA_W-1:0]     Val_Rm_IN,
  input  logic                  imm_IN,
  input  logic [11:0]           Shift_operand_IN,
  input  logic [23:0]           Signed_imm_24_IN,
  input  logic [REG_ADDR_W-1:0] Dest_IN,
  output logic                  Branch_Taken,
  output logic [DATA_W-1:0]     Branch_Address,
  output logic [3:0]            Status,
  output logic                  WB_EN,
  output logic                  MEM_R_EN,
  output logic                  MEM_W_EN,
  output logic [DATA_W-1:0]     ALU_Res,
  output logic [DATA_W-1:0]     Val_Rm,
  output logic [REG_ADDR_W-1:0] Dest
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [DATA_W-1:0]   val2;
  logic [DATA_W-1:0]   imm_ext;
  logic [2*DATA_W-1:0] imm_pair;
  logic [2*DATA_W-1:0] rm_pair;
  logic [4:0]          imm_rot;
  logic [4:0]          sh_amt;

  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W-1:0]   b_op;
  logic [DATA_W:0]     sum;
  logic                cin;
  logic                is_add;
  logic                is_sub;
  logic                n_flag, z_flag, c_flag, v_flag;

  assign imm_ext = {{(DATA_W-8){1'b0}}, Shift_operand_IN[7:0]};
  assign imm_rot = {Shift_operand_IN[11:8], 1'b0};
  assign sh_amt  = Shift_operand_IN[11:7];

  // Second operand: rotated immediate, else memory offset, else shifted Rm
  always_comb begin
    imm_pair = {imm_ext, imm_ext} >> imm_rot;
    rm_pair  = {Val_Rm_IN, Val_Rm_IN} >> sh_amt;
    val2     = Val_Rm_IN;
    if (imm_IN) begin
      val2 = imm_pair[DATA_W-1:0];
    end else if (MEM_R_EN_IN || MEM_W_EN_IN) begin
      val2 = {{(DATA_W-12){1'b0}}, Shift_operand_IN};
    end else begin
      case (Shift_operand_IN[6:5])
        2'b00:   val2 = Val_Rm_IN << sh_amt;
        2'b01:   val2 = Val_Rm_IN >> sh_amt;
        2'b10:   val2 = $signed(Val_Rm_IN) >>> sh_amt;
        default: val2 = rm_pair[DATA_W-1:0];
      endcase
    end
  end

  // ALU: subtraction is done as Rn + ~Val2 + carry so C comes out as NOT borrow
  always_comb begin
    is_add = 1'b0;
    is_sub = 1'b0;
    b_op   = val2;
    cin    = 1'b0;
    case (EXE_CMD_IN)
      CMD_ADD: begin is_add = 1'b1; end
      CMD_ADC: begin is_add = 1'b1; cin = Status[1]; end
      CMD_SUB: begin is_sub = 1'b1; b_op = ~val2; cin = 1'b1; end
      CMD_SBC: begin is_sub = 1'b1; b_op = ~val2; cin = Status[1]; end
      default: ;
    endcase
    sum = {1'b0, Val_Rn_IN} + {1'b0, b_op} + {{DATA_W{1'b0}}, cin};

    case (EXE_CMD_IN)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: alu_res = sum[DATA_W-1:0];
      CMD_AND: alu_res = Val_Rn_IN & val2;
      CMD_ORR: alu_res = Val_Rn_IN | val2;
      CMD_EOR: alu_res = Val_Rn_IN ^ val2;
      default: alu_res = '0;
    endcase

    n_flag = alu_res[DATA_W-1];
    z_flag = (alu_res == '0);
    c_flag = Status[1];
    v_flag = Status[0];
    if (is_add) begin
      c_flag = sum[DATA_W];
      v_flag = (Val_Rn_IN[DATA_W-1] == val2[DATA_W-1]) &&
               (alu_res[DATA_W-1] != Val_Rn_IN[DATA_W-1]);
    end else if (is_sub) begin
      c_flag = sum[DATA_W];
      v_flag = (Val_Rn_IN[DATA_W-1] != val2[DATA_W-1]) &&
               (alu_res[DATA_W-1] != Val_Rn_IN[DATA_W-1]);
    end
  end

  assign Branch_Taken   = B_IN;
  assign Branch_Address = PC_IN + {{(DATA_W-26){Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};

  // Status register: loads only on an unfrozen flag-setting instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Status <= 4'b0000;
    end else if (!freeze && S_IN) begin
      Status <= {n_flag, z_flag, c_flag, v_flag};
    end
  end

  // EXE/MEM pipeline register, held while the pipeline is frozen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WB_EN    <= 1'b0;
      MEM_R_EN <= 1'b0;
      MEM_W_EN <= 1'b0;
      ALU_Res  <= '0;
      Val_Rm   <= '0;
      Dest     <= '0;
    end else if (!freeze) begin
      WB_EN    <= WB_EN_IN;
      MEM_R_EN <= MEM_R_EN_IN;
      MEM_W_EN <= MEM_W_EN_IN;
      ALU_Res  <= alu_res;
      Val_Rm   <= Val_Rm_IN;
      Dest     <= Dest_IN;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: vector table driven through a scoreboard queue,
// plus hand-written branch, freeze and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_exe_stage;

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [11:0] shop;
    logic        s;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [3:0]  dest;
    logic        b;
    logic [31:0] pc;
    logic [23:0] off24;
    logic [31:0] exp_res;
    logic [3:0]  exp_status;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] rm;
    logic [3:0]  status;
    logic [3:0]  dest;
    logic        wb;
    logic        mr;
    logic        mw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
  logic        b_in = 1'b0, s_in = 1'b0, imm_in = 1'b0;
  logic [3:0]  exe_cmd_in = '0;
  logic [31:0] pc_in = '0, val_rn_in = '0, val_rm_in = '0;
  logic [11:0] shift_operand_in = '0;
  logic [23:0] signed_imm_24_in = '0;
  logic [3:0]  dest_in = '0;

  logic        branch_taken;
  logic [31:0] branch_address;
  logic [3:0]  status;
  logic        wb_en, mem_r_en, mem_w_en;
  logic [31:0] alu_res, val_rm;
  logic [3:0]  dest;

  int total = 0;
  int bad   = 0;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t last_exp;

  exe_stage dut (
    .clk              (clk),
    .rst              (rst),
    .freeze           (freeze),
    .WB_EN_IN         (wb_en_in),
    .MEM_R_EN_IN      (mem_r_en_in),
    .MEM_W_EN_IN      (mem_w_en_in),
    .B_IN             (b_in),
    .S_IN             (s_in),
    .EXE_CMD_IN       (exe_cmd_in),
    .PC_IN            (pc_in),
    .Val_Rn_IN        (val_rn_in),
    .Val_Rm_IN        (val_rm_in),
    .imm_IN           (imm_in),
    .Shift_operand_IN (shift_operand_in),
    .Signed_imm_24_IN (signed_imm_24_in),
    .Dest_IN          (dest_in),
    .Branch_Taken     (branch_taken),
    .Branch_Address   (branch_address),
    .Status           (status),
    .WB_EN            (wb_en),
    .MEM_R_EN         (mem_r_en),
    .MEM_W_EN         (mem_w_en),
    .ALU_Res          (alu_res),
    .Val_Rm           (val_rm),
    .Dest             (dest)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input string name, input logic [3:0] cmd,
                              input logic [31:0] rn, input logic [31:0] rm,
                              input logic imm, input logic [11:0] shop,
                              input logic s, input logic wb, input logic mr,
                              input logic mw, input logic [3:0] d,
                              input logic [31:0] er, input logic [3:0] es);
    vec_t v;
    v.name = name; v.cmd = cmd; v.rn = rn; v.rm = rm; v.imm = imm;
    v.shop = shop; v.s = s; v.wb = wb; v.mr = mr; v.mw = mw; v.dest = d;
    v.b = 1'b0; v.pc = '0; v.off24 = '0;
    v.exp_res = er; v.exp_status = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exe_cmd_in       = v.cmd;
    val_rn_in        = v.rn;
    val_rm_in        = v.rm;
    imm_in           = v.imm;
    shift_operand_in = v.shop;
    s_in             = v.s;
    wb_en_in         = v.wb;
    mem_r_en_in      = v.mr;
    mem_w_en_in      = v.mw;
    dest_in          = v.dest;
    b_in             = v.b;
    pc_in            = v.pc;
    signed_imm_24_in = v.off24;
  endtask

  // Drive on the falling edge and record what the register should show next
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    drive(v);
    if (freeze) begin
      e = last_exp;
      e.name = {v.name, "_frozen"};
    end else begin
      e.name = v.name; e.res = v.exp_res; e.rm = v.rm; e.status = v.exp_status;
      e.dest = v.dest; e.wb = v.wb; e.mr = v.mr; e.mw = v.mw;
      last_exp = e;
    end
    sb.push_back(e);
  endtask

  // Sample just after the rising edge and compare against the oldest entry
  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".res"},    alu_res,        e.res);
      chk({e.name, ".status"}, 32'(status),    32'(e.status));
      chk({e.name, ".dest"},   32'(dest),      32'(e.dest));
      chk({e.name, ".val_rm"}, val_rm,         e.rm);
      chk({e.name, ".ctrl"},   32'({wb_en, mem_r_en, mem_w_en}), 32'({e.wb, e.mr, e.mw}));
    end
  endtask

  task automatic checkCleared(input string name);
    chk({name, ".res"},    alu_res,     32'd0);
    chk({name, ".status"}, 32'(status), 32'd0);
    chk({name, ".dest"},   32'(dest),   32'd0);
    chk({name, ".val_rm"}, val_rm,      32'd0);
    chk({name, ".ctrl"},   32'({wb_en, mem_r_en, mem_w_en}), 32'd0);
  endtask

  initial begin
    vec_t v;

    // Vector table; expected flags follow on from the previous row
    vecs.push_back(mk("adds_imm",     4'b0010, 32'd5,        32'd0,        1, 12'h1FF, 1, 1, 0, 0, 4'd1,  32'hC000_0044, 4'b1000));
    vecs.push_back(mk("subs_eq",      4'b0100, 32'd3,        32'd3,        0, 12'h000, 1, 1, 0, 0, 4'd2,  32'h0000_0000, 4'b0110));
    vecs.push_back(mk("adc_cin",      4'b0011, 32'd1,        32'd1,        0, 12'h000, 0, 1, 0, 0, 4'd3,  32'h0000_0003, 4'b0110));
    vecs.push_back(mk("adds_ovf",     4'b0010, 32'h7FFF_FFFF, 32'd1,       0, 12'h000, 1, 1, 0, 0, 4'd4,  32'h8000_0000, 4'b1001));
    vecs.push_back(mk("mov_asr",      4'b0001, 32'd0,        32'h8000_0000, 0, 12'h240, 0, 1, 0, 0, 4'd5,  32'hF800_0000, 4'b1001));
    vecs.push_back(mk("eors_zero",    4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 12'h000, 1, 1, 0, 0, 4'd6, 32'h0000_0000, 4'b0101));
    vecs.push_back(mk("subs_borrow",  4'b0100, 32'd1,        32'd2,        0, 12'h000, 1, 1, 0, 0, 4'd7,  32'hFFFF_FFFF, 4'b1000));
    vecs.push_back(mk("sbcs",         4'b0101, 32'd10,       32'd0,        1, 12'h003, 1, 1, 0, 0, 4'd8,  32'h0000_0006, 4'b0010));
    vecs.push_back(mk("adcs_wrap",    4'b0011, 32'hFFFF_FFFE, 32'd0,       1, 12'h001, 1, 1, 0, 0, 4'd9,  32'h0000_0000, 4'b0110));
    vecs.push_back(mk("orrs_lsl",     4'b0111, 32'h0000_00F0, 32'h0000_000F, 0, 12'h400, 1, 1, 0, 0, 4'd10, 32'h0000_0FF0, 4'b0010));
    vecs.push_back(mk("and_lsr",      4'b0110, 32'hFFFF_FFFF, 32'h8000_0000, 0, 12'hFA0, 0, 1, 0, 0, 4'd11, 32'h0000_0001, 4'b0010));
    vecs.push_back(mk("mov_ror",      4'b0001, 32'd0,        32'h0000_00F1, 0, 12'h260, 0, 1, 0, 0, 4'd12, 32'h1000_000F, 4'b0010));
    vecs.push_back(mk("str_off",      4'b0010, 32'h0000_1000, 32'hDEAD_BEEF, 0, 12'hFFF, 0, 0, 0, 1, 4'd13, 32'h0000_1FFF, 4'b0010));
    vecs.push_back(mk("undef_s",      4'b0000, 32'h0000_1234, 32'h0000_5678, 0, 12'h000, 1, 0, 0, 0, 4'd14, 32'h0000_0000, 4'b0110));
    vecs.push_back(mk("imm_over_mem", 4'b0010, 32'd0,        32'd0,        1, 12'h4FF, 0, 1, 1, 0, 4'd15, 32'hFF00_0000, 4'b0110));
    vecs.push_back(mk("subs_ovf",     4'b0100, 32'h8000_0000, 32'd1,       0, 12'h000, 1, 1, 0, 0, 4'd0,  32'h7FFF_FFFF, 4'b0011));
    vecs.push_back(mk("mvns_imm",     4'b1001, 32'd0,        32'd0,        1, 12'h0FF, 1, 1, 0, 0, 4'd1,  32'hFFFF_FF00, 4'b1011));

    // Reset held with live ADD inputs, then released without a clock edge
    drive(vecs[0]);
    #1;
    checkCleared("reset_hold");
    #1 rst = 1'b1;
    #1;
    checkCleared("reset_release");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Branches: target is combinational in the same cycle; flags still update
    v = mk("branch_back", 4'b0001, 32'd0, 32'd0, 1, 12'h000, 1, 0, 0, 0, 4'd0, 32'd0, 4'b0111);
    v.b = 1'b1; v.pc = 32'h0000_0100; v.off24 = 24'hFFFFFE;
    applyStimulus(v);
    #1;
    chk("branch_back.taken", 32'(branch_taken), 32'd1);
    chk("branch_back.addr",  branch_address,    32'h0000_00F8);
    checkOutput();

    v = mk("branch_fwd", 4'b0000, 32'd0, 32'd0, 0, 12'h000, 0, 0, 0, 0, 4'd0, 32'd0, 4'b0111);
    v.b = 1'b1; v.pc = 32'h0000_1000; v.off24 = 24'h000010;
    applyStimulus(v);
    #1;
    chk("branch_fwd.addr", branch_address, 32'h0000_1040);
    checkOutput();

    v = mk("branch_min", 4'b0000, 32'd0, 32'd0, 0, 12'h000, 0, 0, 0, 0, 4'd0, 32'd0, 4'b0111);
    v.b = 1'b1; v.pc = 32'h0000_0000; v.off24 = 24'h800000;
    applyStimulus(v);
    #1;
    chk("branch_min.addr", branch_address, 32'hFE00_0000);
    checkOutput();

    v = mk("flushed", 4'b0000, 32'd0, 32'd0, 0, 12'h000, 0, 0, 0, 0, 4'd0, 32'd0, 4'b0111);
    applyStimulus(v);
    #1;
    chk("flushed.taken", 32'(branch_taken), 32'd0);
    checkOutput();

    // Load followed by a two-cycle freeze with a pending SUBS
    v = mk("ldr", 4'b0010, 32'h0000_0400, 32'd0, 0, 12'h004, 0, 1, 1, 0, 4'd7, 32'h0000_0404, 4'b0111);
    applyStimulus(v);
    checkOutput();
    freeze = 1'b1;
    v = mk("subs_held", 4'b0100, 32'd0, 32'd1, 0, 12'h000, 1, 0, 0, 0, 4'd9, 32'hFFFF_FFFF, 4'b1000);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(v);
      checkOutput();
    end
    freeze = 1'b0;
    applyStimulus(v);
    checkOutput();
    v = mk("sbc_after", 4'b0101, 32'd5, 32'd0, 1, 12'h001, 0, 1, 0, 0, 4'd3, 32'h0000_0003, 4'b1000);
    applyStimulus(v);
    checkOutput();

    // Asynchronous reset in the middle of a stall
    freeze = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkCleared("reset_in_stall");
    #1 rst = 1'b1;
    #1;
    checkCleared("reset_in_stall_release");
    @(posedge clk);
    #1;
    checkCleared("reset_in_stall_held");
    freeze = 1'b0;
    last_exp = '{name: "cleared", res: 32'd0, rm: 32'd0, status: 4'd0, dest: 4'd0, wb: 1'b0, mr: 1'b0, mw: 1'b0};

    // Carry flag must be clear again after reset
    v = mk("adc_after_reset", 4'b0011, 32'd1, 32'd0, 1, 12'h001, 0, 1, 0, 0, 4'd2, 32'h0000_0002, 4'b0000);
    applyStimulus(v);
    checkOutput();

    if (sb.size() != 0) chk("scoreboard_leftover", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
Execute stage of the 5-stage ARM-subset pipeline. It consumes the decoded fields latched by the ID/EXE stage register. It contains the Val2 generator, ALU, branch-target adder, the NZCV status register and the EXE/MEM pipeline register. Its registered outputs feed the MEM stage. Branch_Taken/Branch_Address go combinationally back to IF and drive the flush of the IF/ID and ID/EXE registers.

Parameters:
DATA_W, 32, datapath width (ALU, PC, register values); only 32 is supported.
REG_ADDR_W, 4, destination register index width.

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low; clears all state
freeze  input  1  hazard stall; holds the EXE/MEM register and status register
WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN  input  1 each  control bits from the ID/EXE register
EXE_CMD_IN  input  4  ALU command
PC_IN  input  32  PC+4 of the instruction
Val_Rn_IN, Val_Rm_IN  input  32 each  register operands
imm_IN  input  1  immediate operand select
Shift_operand_IN  input  12  shifter operand / memory offset
Signed_imm_24_IN  input  24  branch offset in words
Dest_IN  input  4  destination register
Branch_Taken  output  1  combinational, equals B_IN
Branch_Address  output  32  combinational branch target
Status  output  4  registered {N,Z,C,V}
WB_EN, MEM_R_EN, MEM_W_EN  output  1 each  registered control bits
ALU_Res  output  32  registered ALU result / memory address
Val_Rm  output  32  registered store data
Dest  output  4  registered destination register

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-stall): Status, WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm and Dest go to 0 immediately.
- Val2 generation, evaluated in this priority order:
  - imm_IN=1: zero-extended Shift_operand_IN[7:0], rotated right by 2*Shift_operand_IN[11:8].
  - Else if MEM_R_EN_IN or MEM_W_EN_IN: zero-extended Shift_operand_IN[11:0].
  - Else: Val_Rm_IN shifted by Shift_operand_IN[11:7] (0..31). Type from [6:5]: 00 LSL, 01 LSR, 10 ASR (sign fill), 11 ROR. Shift amount 0 passes Val_Rm_IN unchanged.
- ALU commands (EXE_CMD_IN):
  - 0001 MOV = Val2; 1001 MVN = ~Val2.
  - 0010 ADD (also LDR/STR) = Rn+Val2; 0011 ADC = Rn+Val2+C.
  - 0100 SUB/CMP = Rn-Val2; 0101 SBC = Rn-Val2-(~C).
  - 0110 AND/TST, 0111 ORR, 1000 EOR.
  - Any other code: result 0, flags computed as for a logic op.
  - C in ADC/SBC is the current registered Status[1].
- Flags:
  - N = res[31]; Z = (res==0).
  - Add ops: C = carry out of bit 31. Sub ops: C = NOT borrow.
  - V (add/sub only) = signed overflow: operands of equal sign (add) or differing sign (sub) and result sign differs from Rn.
  - Logic/MOV/MVN/undefined: C and V keep their current values.
- Status register: on rising clk with freeze=0 and S_IN=1, load {N,Z,C,V}; otherwise hold. S_IN and B_IN together: Status still updates.
- Branch_Address = PC_IN + (sign-extend Signed_imm_24_IN to 32 bits << 2), modulo 2^32. Valid in the same cycle as B_IN. A flushed slot arrives as all-zero fields, so Branch_Taken=0.
- EXE/MEM register, on rising clk:
  - freeze=0: capture WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, ALU result, Val_Rm_IN, Dest_IN. Latency is 1 cycle from input to registered output.
  - freeze=1: all registered outputs and Status hold; the instruction is re-presented later without double-updating flags.
- All arithmetic is 32-bit wrap-around; no exceptions.

Test Plan:
1. Drive valid ADD inputs, assert rst=0 between clock edges -> all registered outputs and Status read 0 immediately; after release with no edge, they stay 0.
2. EXE_CMD=0010, Val_Rn=5, imm=1, Shift_operand=12'h1FF, S=1 -> next cycle ALU_Res=0xC0000044, Status=4'b1000.
3. EXE_CMD=0100, Val_Rn=3, Val_Rm=3, imm=0, Shift_operand=0, S=1 -> ALU_Res=0, Status=4'b0110. Then EXE_CMD=0011 with Val_Rn=1, Val2=1 -> ALU_Res=3 (carry-in used).
4. ADD 0x7FFFFFFF+1 (Val_Rm=1, LSL #0), S=1 -> ALU_Res=0x80000000, Status=4'b1001. Register operand Val_Rm=0x80000000 with Shift_operand ASR #4 (12'h240) under MOV -> ALU_Res=0xF8000000.
5. B_IN=1, PC_IN=0x100, Signed_imm_24=24'hFFFFFE -> same cycle Branch_Taken=1, Branch_Address=0xF8.
6. LDR: MEM_R_EN=1, WB_EN=1, EXE_CMD=0010, Val_Rn=0x400, Shift_operand=12'h004, Dest=7 -> ALU_Res=0x404, Dest=7. Then freeze=1 for 2 cycles with new SUBS inputs -> outputs and Status unchanged until freeze=0.
